exec_seq_ctrl: RTL
==================

EXEC_SEQ_CTRL -- requirements
Module: exec_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning max wait cycles for mem_ack before aborting a load.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL be reset asynchronously on rst high and SHALL sample on the rising clk edge.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 id_valid  in  1  decode stage presents an instruction.
REQ-006 id_ready  out  1  controller accepts the instruction this cycle.
REQ-007 id_alu_ctrl  in  3  ALU opcode; for loads, bit0 selects 0=LI, 1=LW.
REQ-008 id_load_op  in  1  instruction is a load (LI/LW).
REQ-009 id_rd, id_rs1, id_rs2  in  3 each  destination and source register indices.
REQ-010 ex_alu_ctrl  out  3  registered opcode driven to the execution unit.
REQ-011 ex_load_op  out  1  registered load flag driven to the execution unit.
REQ-012 ex_rd  out  3  registered destination index.
REQ-013 mem_req  out  1  data-memory read request for LW.
REQ-014 mem_ack  in  1  memory data valid, sampled while mem_req is high.
REQ-015 ex_valid  out  1  EX result valid for writeback.
REQ-016 ex_err  out  1  result aborted by timeout; valid only with ex_valid.
REQ-017 wb_ready  in  1  writeback accepts the result.
REQ-018 wb_we, wb_rd  in  1, 3  writeback stage write enable and index.
REQ-019 fwd_sel1, fwd_sel2  out  2 each  operand source: 00 regfile, 01 EX result, 10 WB result.

Function
REQ-020 States SHALL be IDLE, MEM, DONE.
REQ-021 id_ready SHALL equal (state==IDLE) or (state==DONE and wb_ready).
REQ-022 On id_valid and id_ready, ex_alu_ctrl, ex_load_op and ex_rd SHALL register the id_* fields; next state SHALL be MEM if id_load_op and id_alu_ctrl[0] are 1 (LW), else DONE.
REQ-023 ALU and LI latency SHALL be 1 cycle: ex_valid high in the cycle after acceptance.
REQ-024 In MEM, mem_req SHALL be high; mem_req SHALL be low in all other states.
REQ-025 In MEM, mem_ack high SHALL move to DONE with ex_err=0; a 4-bit wait counter SHALL increment each cycle without ack.
REQ-026 When the wait counter reaches MEM_TIMEOUT without ack, the block SHALL drop mem_req and enter DONE with ex_err=1; mem_ack arriving in that same cycle SHALL take priority (ex_err=0).
REQ-027 The wait counter SHALL clear on entering MEM.
REQ-028 In DONE, ex_valid SHALL be high and all ex_* outputs SHALL be held stable until wb_ready.
REQ-029 DONE with wb_ready SHALL go to IDLE if no new instruction is accepted; with id_valid it SHALL accept back-to-back, with no bubble.
REQ-030 fwd_selN SHALL be 01 if state==DONE and id_rsN==ex_rd, else 10 if wb_we and id_rsN==wb_rd, else 00; EX match SHALL win over WB, and index 0 SHALL always give 00.
REQ-031 fwd_sel outputs SHALL be combinational from current inputs and state.

Reset
REQ-032 On rst: state IDLE, ex_alu_ctrl=0, ex_load_op=0, ex_rd=0, counter=0, ex_err=0, mem_req=0, ex_valid=0.
REQ-033 Reset asserted mid-MEM SHALL drop mem_req immediately and discard the pending load; no ex_valid SHALL follow.

Structure
REQ-034 The shared package exu_pkg SHALL hold the state enum, the LI/LW bit0 encoding, the fwd_sel encodings and the MEM_TIMEOUT default.
REQ-035 A sub-module fwd_compare SHALL implement one operand's forwarding select and SHALL be instantiated twice.

Verification
REQ-036 ADD (alu_ctrl=000, rd=3) accepted at cycle 0 with wb_ready=1 -> ex_valid high at cycle 1, ex_rd=3, mem_req never high.
REQ-037 LW (load_op=1, alu_ctrl=001) with mem_ack on the 3rd request cycle -> mem_req high for 3 cycles, then ex_valid high and ex_err=0.
REQ-038 LW with no mem_ack, MEM_TIMEOUT=15 -> mem_req drops after 15 cycles, ex_valid=1 with ex_err=1.
REQ-039 EX holds rd=2 and WB writes rd=2; decode rs1=2, rs2=0 -> fwd_sel1=01, fwd_sel2=00.
REQ-040 wb_ready low for 4 cycles in DONE -> ex_valid and ex_* stay constant and id_ready=0; on release, the next instruction is accepted in the same cycle.
REQ-041 rst pulsed during MEM -> mem_req=0 and ex_valid=0 immediately, state IDLE.

Source files
------------

// File: rtl/exu_pkg.sv
// exu_pkg - shared definitions for the execution sequencing controller.
//   exu_state_e     : controller states (IDLE, MEM, DONE)
//   LOAD_SEL_LI/LW  : value of alu_ctrl[0] that distinguishes LI from LW
//   FWD_*           : operand forwarding select encodings
//   MEM_TIMEOUT_DEFAULT : default memory-ack wait limit in cycles
package exu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } exu_state_e;

  localparam logic LOAD_SEL_LI = 1'b0;
  localparam logic LOAD_SEL_LW = 1'b1;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX      = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  localparam int MEM_TIMEOUT_DEFAULT = 15;
  localparam int WAIT_CNT_W          = 4;

  // Only LW needs the memory round trip; LI completes like an ALU op.
  function automatic logic is_lw(input logic load_op, input logic alu_bit0);
    return load_op && (alu_bit0 == LOAD_SEL_LW);
  endfunction

endpackage

// File: rtl/exec_seq_ctrl_if.sv
// exec_seq_ctrl_if - bundle of the decode, execute, memory and writeback
// signals seen by the sequencing controller.
//   slave  : controller side (takes id_*, mem_ack, wb_*; drives ex_*, mem_req, fwd_sel*)
//   master : environment side (the opposite directions)
interface exec_seq_ctrl_if;

  logic       id_valid;
  logic       id_ready;
  logic [2:0] id_alu_ctrl;
  logic       id_load_op;
  logic [2:0] id_rd;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;

  logic [2:0] ex_alu_ctrl;
  logic       ex_load_op;
  logic [2:0] ex_rd;
  logic       ex_valid;
  logic       ex_err;

  logic       mem_req;
  logic       mem_ack;

  logic       wb_ready;
  logic       wb_we;
  logic [2:0] wb_rd;

  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;

  modport slave (
    input  id_valid, id_alu_ctrl, id_load_op, id_rd, id_rs1, id_rs2,
    input  mem_ack, wb_ready, wb_we, wb_rd,
    output id_ready, ex_alu_ctrl, ex_load_op, ex_rd, ex_valid, ex_err,
    output mem_req, fwd_sel1, fwd_sel2
  );

  modport master (
    output id_valid, id_alu_ctrl, id_load_op, id_rd, id_rs1, id_rs2,
    output mem_ack, wb_ready, wb_we, wb_rd,
    input  id_ready, ex_alu_ctrl, ex_load_op, ex_rd, ex_valid, ex_err,
    input  mem_req, fwd_sel1, fwd_sel2
  );

endinterface

// File: rtl/fwd_compare.sv
// fwd_compare - operand forwarding select for one source register.
//   ex_hit_en : the EX stage holds a finished result (controller in DONE)
//   rs        : source register index from decode
//   ex_rd     : destination index of the result held in EX
//   wb_we/wb_rd : writeback stage write enable and destination index
//   fwd_sel   : FWD_REGFILE / FWD_EX / FWD_WB
module fwd_compare
  import exu_pkg::*;
(
  input  logic       ex_hit_en,
  input  logic [2:0] rs,
  input  logic [2:0] ex_rd,
  input  logic       wb_we,
  input  logic [2:0] wb_rd,
  output logic [1:0] fwd_sel
);

  // Register 0 is never forwarded. The EX result is younger than the WB
  // result, so an EX match takes priority.
  always_comb begin
    fwd_sel = FWD_REGFILE;
    if (rs != 3'd0) begin
      if (ex_hit_en && (rs == ex_rd)) begin
        fwd_sel = FWD_EX;
      end else if (wb_we && (rs == wb_rd)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl - sequences one instruction at a time from decode into the
// execution unit, runs the data-memory handshake for LW with a timeout, holds
// the result until writeback takes it, and computes operand forwarding.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : exec_seq_ctrl_if.slave (decode, EX, memory, WB, forwarding)
//   MEM_TIMEOUT : max cycles to wait for mem_ack before aborting an LW (1..15)
module exec_seq_ctrl
  import exu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  exec_seq_ctrl_if.slave  bus
);

  // The wait counter is 4 bits wide, so the limit is narrowed once here.
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

  exu_state_e            state_q, state_d;
  logic [2:0]            ex_alu_ctrl_q, ex_alu_ctrl_d;
  logic                  ex_load_op_q, ex_load_op_d;
  logic [2:0]            ex_rd_q, ex_rd_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  ex_err_q, ex_err_d;
  logic                  mem_req_q, mem_req_d;
  logic                  ex_valid_q, ex_valid_d;

  logic                  id_ready;
  logic                  accept;
  logic [WAIT_CNT_W-1:0] wait_cnt_inc;

  // Next-state logic. A new instruction may be taken in IDLE, or in DONE in
  // the same cycle writeback consumes the current result, so back-to-back
  // instructions see no bubble. mem_req and ex_valid are registered copies of
  // the next state, which keeps them glitch-free and lets reset drop them
  // immediately.
  always_comb begin
    id_ready      = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.wb_ready);
    accept        = bus.id_valid && id_ready;
    wait_cnt_inc  = wait_cnt_q + 1'b1;

    state_d       = state_q;
    ex_alu_ctrl_d = ex_alu_ctrl_q;
    ex_load_op_d  = ex_load_op_q;
    ex_rd_d       = ex_rd_q;
    wait_cnt_d    = wait_cnt_q;
    ex_err_d      = ex_err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          ex_alu_ctrl_d = bus.id_alu_ctrl;
          ex_load_op_d  = bus.id_load_op;
          ex_rd_d       = bus.id_rd;
          ex_err_d      = 1'b0;
          if (is_lw(bus.id_load_op, bus.id_alu_ctrl[0])) begin
            state_d    = ST_MEM;
            wait_cnt_d = '0;
          end else begin
            state_d    = ST_DONE;
          end
        end else if ((state_q == ST_DONE) && bus.wb_ready) begin
          state_d  = ST_IDLE;
          ex_err_d = 1'b0;
        end
      end

      ST_MEM: begin
        // An ack arriving in the timeout cycle still counts as success.
        if (bus.mem_ack) begin
          state_d  = ST_DONE;
          ex_err_d = 1'b0;
        end else if (wait_cnt_inc == TIMEOUT_CNT) begin
          state_d    = ST_DONE;
          ex_err_d   = 1'b1;
          wait_cnt_d = wait_cnt_inc;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_d  = (state_d == ST_MEM);
    ex_valid_d = (state_d == ST_DONE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ex_alu_ctrl_q <= '0;
      ex_load_op_q  <= 1'b0;
      ex_rd_q       <= '0;
      wait_cnt_q    <= '0;
      ex_err_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      ex_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ex_alu_ctrl_q <= ex_alu_ctrl_d;
      ex_load_op_q  <= ex_load_op_d;
      ex_rd_q       <= ex_rd_d;
      wait_cnt_q    <= wait_cnt_d;
      ex_err_q      <= ex_err_d;
      mem_req_q     <= mem_req_d;
      ex_valid_q    <= ex_valid_d;
    end
  end

  assign bus.id_ready    = id_ready;
  assign bus.ex_alu_ctrl = ex_alu_ctrl_q;
  assign bus.ex_load_op  = ex_load_op_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_err      = ex_err_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.ex_valid    = ex_valid_q;

  fwd_compare u_fwd_rs1 (
    .ex_hit_en (state_q == ST_DONE),
    .rs        (bus.id_rs1),
    .ex_rd     (ex_rd_q),
    .wb_we     (bus.wb_we),
    .wb_rd     (bus.wb_rd),
    .fwd_sel   (bus.fwd_sel1)
  );

  fwd_compare u_fwd_rs2 (
    .ex_hit_en (state_q == ST_DONE),
    .rs        (bus.id_rs2),
    .ex_rd     (ex_rd_q),
    .wb_we     (bus.wb_we),
    .wb_rd     (bus.wb_rd),
    .fwd_sel   (bus.fwd_sel2)
  );

endmodule
